// File: rtl/uart_rx_frontend_if.sv
// Byte handshake between the UART receive front end and its consumer (the UART MMIO read path).
// The producer (master) drives data_out/data_out_valid; the consumer (slave) drives data_out_ready.
interface uart_rx_frontend_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, ready/valid byte output, framing/overrun flags.
// Optional `UART_RX_PARITY_EN adds an even-parity bit between bit 7 and the stop bit.
module uart_rx_frontend #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  uart_rx_frontend_if.master  rx_if,
  output logic                framing_error,
  output logic                overrun
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_WRAP   = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_SAMPLE = CLOCK_COUNTER_WIDTH'(SAMPLE_TIME);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  logic                           sync1_q, sync2_q;
  logic [2:0]                     state_q, state_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]                     bit_cnt_q, bit_cnt_d;
  logic [7:0]                     shreg_q, shreg_d;
  logic [7:0]                     data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           ferr_q, ferr_d;
  logic                           ovr_q, ovr_d;

  logic rx_s;
  logic sample;
  logic accept;

  assign rx_s   = sync2_q;
  assign sample = (clk_cnt_q == CNT_SAMPLE);
  assign accept = valid_q && rx_if.data_out_ready;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = (clk_cnt_q == CNT_WRAP) ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;

    // A commit in STOP below overrides this, keeping valid high across a same-edge accept.
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) begin
          if (^{shreg_q, rx_s}) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end else begin
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (sample) begin
          if (rx_s) begin
            if (!valid_q || rx_if.data_out_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= serial_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_if.data_out       = data_q;
  assign rx_if.data_out_valid = valid_q;
  assign framing_error        = ferr_q;
  assign overrun              = ovr_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed frames plus random frames against a frame-level model.
// Runs at a reduced clock/baud ratio (43 cycles per bit) so many frames fit in a short run.
module tb_uart_rx_frontend;

  localparam int CLK_HZ    = 5_000_000;
  localparam int BAUD      = 115_200;
  localparam int BIT       = CLK_HZ / BAUD;
  localparam int HALF      = BIT / 2;
  // Start edge -> 2 sync flops -> IDLE edge, then half a bit plus 9 full bits to the stop sample.
  localparam int STOP_EDGE = 3 + HALF + 1 + 9 * BIT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b1;
  logic framing_error, overrun;

  uart_rx_frontend_if rx_if ();

  uart_rx_frontend #(
    .CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .rx_if        (rx_if),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned ferr_cnt = 0;
  int unsigned rise_cyc = 0;
  logic        vprev = 1'b0;
  always @(negedge clk) begin
    if (framing_error) ferr_cnt <= ferr_cnt + 1;
    if (rx_if.data_out_valid && !vprev) rise_cyc <= cyc;
    vprev <= rx_if.data_out_valid;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference model
  bit          exp_valid = 1'b0;
  logic [7:0]  exp_data  = 8'h00;
  bit          exp_ovr   = 1'b0;
  int unsigned exp_ferr  = 0;

  int unsigned t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_state(input string tag);
    check({tag, ".valid"}, 32'(rx_if.data_out_valid), 32'(exp_valid));
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    check({tag, ".ferr_cnt"}, ferr_cnt, exp_ferr);
    if (exp_valid) check({tag, ".data"}, 32'(rx_if.data_out), 32'(exp_data));
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit ready_at_stop);
    if (!stop_ok) begin
      exp_ferr++;
    end else if (!exp_valid || ready_at_stop) begin
      exp_data  = d;
      exp_valid = 1'b1;
      exp_ovr   = 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic model_accept();
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, output int unsigned start_cyc);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1;
    rx_if.data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_if.data_out_ready = 1'b0;
    model_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] d;
    bit         bad;
    rx_if.data_out_ready = 1'b0;

    // 1: reset, 0xA5, latency, hold until ready
    idle(3);
    check("rst.data", 32'(rx_if.data_out), 32'h00);
    compare_state("rst");
    rst = 1'b1;
    idle(5);
    send_frame(8'hA5, 1'b1, t0);
    model_frame(8'hA5, 1'b1, 1'b0);
    check("t1.latency", rise_cyc - t0, STOP_EDGE);
    compare_state("t1");
    idle(37);
    compare_state("t1.hold");
    pulse_ready();
    compare_state("t1.accept");

    // 2: short glitch rejected, then 0x3C
    serial_in = 1'b0;
    idle(BIT / 4);
    serial_in = 1'b1;
    idle(12 * BIT);
    compare_state("t2.glitch");
    send_frame(8'h3C, 1'b1, t0);
    model_frame(8'h3C, 1'b1, 1'b0);
    compare_state("t2");
    pulse_ready();

    // 3: overrun
    send_frame(8'h11, 1'b1, t0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, t0);
    model_frame(8'h22, 1'b1, 1'b0);
    compare_state("t3.ovr");
    pulse_ready();
    compare_state("t3.clear");

    // 4: accept on the very edge a new byte commits
    send_frame(8'h44, 1'b1, t0);
    model_frame(8'h44, 1'b1, 1'b0);
    fork
      send_frame(8'h55, 1'b1, t0);
      begin
        @(posedge clk);
        #1;
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        rx_if.data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_if.data_out_ready = 1'b0;
      end
    join
    model_frame(8'h55, 1'b1, 1'b1);
    compare_state("t4");
    pulse_ready();

    // 5: stop bit low, line held low, then 0x81
    send_frame(8'h7E, 1'b0, t0);
    idle(2 * BIT);
    model_frame(8'h7E, 1'b0, 1'b0);
    compare_state("t5.ferr");
    serial_in = 1'b1;
    idle(BIT);
    send_frame(8'h81, 1'b1, t0);
    model_frame(8'h81, 1'b1, 1'b0);
    compare_state("t5");

    // 6: reset during bit 4 of 0xF0 while a byte is pending
    pat = 8'hF0;
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pat[i]);
    serial_in = pat[4];
    idle(HALF);
    rst = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    check("t6.rst.data", 32'(rx_if.data_out), 32'h00);
    compare_state("t6.rst");
    serial_in = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(12 * BIT);
    compare_state("t6.after");
    send_frame(8'h0F, 1'b1, t0);
    model_frame(8'h0F, 1'b1, 1'b0);
    compare_state("t6");

    // random frames, random accepts and stop-bit errors
    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) pulse_ready();
      send_frame(d, !bad, t0);
      if (bad) begin
        idle(BIT);
        serial_in = 1'b1;
      end
      model_frame(d, !bad, 1'b0);
      idle($urandom_range(4, BIT));
      compare_state("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Serial receive stage directly upstream of the Riscv151 memory-mapped UART data register; it converts FPGA_SERIAL_RX into bytes.
- Synchronises the asynchronous line, detects and validates 8N1 frames, and samples each bit at mid-bit.
- Presents each received byte on a ready/valid interface that the CPU's UART MMIO read path consumes.
- Reports framing and overrun errors.

Parameters:
CLOCK_FREQ, 50_000_000, core clock frequency in Hz (matches CPU_CLOCK_FREQ).
BAUD_RATE, 115_200, serial bit rate.
(Derived, localparam) SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE using integer division (434 at the defaults). SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (217). CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME).

Ports:
clk  input  1  core clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset. Assertion (0) resets immediately; release is sampled on clk.
serial_in  input  1  raw FPGA_SERIAL_RX line; idles high.
data_out  output  8  received byte, LSB first on the wire.
data_out_valid  output  1  byte available.
data_out_ready  input  1  consumer accepts the byte.
framing_error  output  1  one-cycle pulse when the stop bit samples 0.
overrun  output  1  sticky flag: a byte was dropped because the previous one was unread.

Behaviour:
- Reset values: data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0. Synchroniser flops reset to 1. FSM resets to IDLE with counters at 0.
- Synchroniser: 2-flop chain on serial_in; rx_s is the second flop. All logic uses rx_s only.
- FSM states are IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: go to START when rx_s==0, clearing clk_cnt.
- Bit timing: clk_cnt increments every cycle, wrapping to 0 at SYMBOL_EDGE_TIME-1. A sample fires when clk_cnt==SAMPLE_TIME.
- START: at the sample, if rx_s==1 treat it as a glitch and return to IDLE. Otherwise go to DATA with bit_cnt=0.
- DATA: at each sample, shift rx_s into shreg[7] (right shift, LSB first) and increment bit_cnt. After the 8th sample, go to STOP.
- STOP, sample rx_s==1:
  - If data_out_valid==0, or data_out_ready==1 in that same cycle: load data_out<=shreg and set data_out_valid<=1.
  - Else (previous byte still unread): keep the old data_out, set overrun<=1, drop the new byte.
  - Then go to IDLE.
- STOP, sample rx_s==0: pulse framing_error for one cycle, produce no valid byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents re-triggering on a break or held-low line.
- Handshake:
  - data_out_valid falls on the clock edge where valid&&ready, unless a new byte commits on that same edge; in that case it stays 1 with the new data.
  - data_out is stable whenever valid is high.
- overrun clears only on an accepting handshake (valid&&ready) or on reset.
- Latency: the falling edge of serial_in propagates through the 2 synchroniser cycles. data_out_valid then rises on the edge after the stop-bit mid-sample, at ≈9.5 bit times + 3 cycles after the start edge.
- Reset asserted mid-frame: all state clears immediately; the partial byte is discarded; no spurious valid after release.

Optional Feature:
UART_RX_PARITY_EN
- Defined: an even-parity bit is expected between bit 7 and the stop bit, handled by an extra PARITY state sampled like a data bit. Mismatch makes the frame count as a framing error: framing_error pulses, no byte is delivered, and the FSM goes to WAIT_IDLE.
- Undefined: 8N1 only; no PARITY state is synthesised.

Test Plan:
1. Reset with rst=0, serial_in=1 -> all outputs 0. Release, then drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 434 cycles/bit -> data_out=8'hA5, data_out_valid=1 held until ready; valid drops on the edge where ready=1.
2. Glitch rejection: serial_in low for 100 cycles then high -> no valid, FSM back in IDLE. A following frame 0x3C is received correctly.
3. Overrun: send 0x11, keep ready=0, send 0x22 -> data_out stays 8'h11, overrun=1. Pulse ready -> overrun=0, valid=0.
4. Simultaneous accept/commit: assert ready on exactly the stop-sample edge of a second frame 0x55 -> valid stays 1, data_out=8'h55, overrun=0.
5. Framing error: frame 0x7E with stop bit 0 and line held low for 2 bit times -> framing_error single-cycle pulse, no valid. Next frame 0x81 is received correctly only after the line returns high.
6. Reset mid-frame: assert rst=0 during bit 4 of 0xF0 -> outputs reset immediately. After release, no valid byte from the truncated frame; the next frame 0x0F is received correctly.
